// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
//   Shared definitions for the pipelined scan multiplexer family.
//   - MODE_DIRECT / MODE_SCAN : encodings of the Mode input
//   - clog2()                 : ceiling log2, used to size select fields
// ---------------------------------------------------------------------------
package mux_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Smallest r with 2**r >= n; clog2(1) is 0, clog2(5) is 3, clog2(32) is 5.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/scan_index_counter.sv
// ---------------------------------------------------------------------------
// scan_index_counter
//   Channel index for scan mode. Walks 0..CHANNELS-1 one position per step
//   and wraps to 0. Held at 0 while clear is high, so every entry into scan
//   mode starts at channel 0.
// Ports
//   Clock    in   rising-edge clock
//   Reset_n  in   asynchronous active-low reset (index -> 0)
//   clear    in   force index to 0 (direct mode)
//   step     in   advance index (accepted transfer in scan mode)
//   index    out  current index
//   last     out  index is CHANNELS-1; the next step wraps
// ---------------------------------------------------------------------------
module scan_index_counter
   import mux_pkg::*;
#(
   parameter int CHANNELS = 32,
   parameter int SEL_W    = clog2(CHANNELS)
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             clear,
   input  logic             step,
   output logic [SEL_W-1:0] index,
   output logic             last
);

   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

   assign last = (index == LAST_IDX);

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         index <= '0;
      end else if (clear) begin
         index <= '0;
      end else if (step) begin
         // Explicit wrap: CHANNELS need not be a power of two.
         index <= last ? '0 : index + 1'b1;
      end
   end

endmodule

// File: rtl/pipelined_scan_mux.sv
// ---------------------------------------------------------------------------
// pipelined_scan_mux
//   CHANNELS:1 selector of WIDTH-bit words with a registered output stage
//   and a valid/ready handshake on both sides. The channel comes from Sel
//   (direct mode) or from an internal wrapping index (scan mode).
// Ports
//   Clock     in   rising-edge clock
//   Reset_n   in   asynchronous active-low reset
//   Enable    in   0 blocks new transfers (InReady = 0); output still drains
//   Mode      in   MODE_DIRECT: channel = Sel; MODE_SCAN: channel = scan index
//   Sel       in   channel index used in direct mode
//   MuxIn     in   flat inputs; channel k = MuxIn[k*WIDTH +: WIDTH]
//   InValid   in   producer offers a capture request
//   InReady   out  stage can capture this cycle (combinational)
//   MuxOut    out  registered selected word (0 on a direct-mode range error)
//   OutSel    out  index that produced MuxOut
//   OutLast   out  MuxOut came from index CHANNELS-1 in scan mode
//   OutErr    out  direct-mode Sel was >= CHANNELS
//   OutValid  out  output word and flags are valid
//   OutReady  in   consumer takes the current output
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holding valid must keep its payload stable until
// the transfer; the output side holds MuxOut/OutSel/OutLast/OutErr/OutValid
// stable while OutValid && !OutReady. InReady = Enable && (!OutValid ||
// OutReady), so a new word may replace one being taken in the same cycle
// (one word per cycle at full throughput).
// ---------------------------------------------------------------------------
module pipelined_scan_mux
   import mux_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 32,
   parameter int SEL_W    = clog2(CHANNELS)
) (
   input  logic                      Clock,
   input  logic                      Reset_n,
   input  logic                      Enable,
   input  logic                      Mode,
   input  logic [SEL_W-1:0]          Sel,
   input  logic [CHANNELS*WIDTH-1:0] MuxIn,
   input  logic                      InValid,
   output logic                      InReady,
   output logic [WIDTH-1:0]          MuxOut,
   output logic [SEL_W-1:0]          OutSel,
   output logic                      OutLast,
   output logic                      OutErr,
   output logic                      OutValid,
   input  logic                      OutReady
);

   logic             accept;
   logic [SEL_W-1:0] scanIndex;
   logic             scanLast;
   logic [SEL_W-1:0] idx;
   logic             inRange;
   logic [WIDTH-1:0] word;

   assign InReady = Enable && (!OutValid || OutReady);
   assign accept  = InValid && InReady;

   scan_index_counter #(
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
   ) uScanIndex (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .clear   (Mode == MODE_DIRECT),
      .step    (accept && (Mode == MODE_SCAN)),
      .index   (scanIndex),
      .last    (scanLast)
   );

   // Word select. Sel can encode more values than there are channels when
   // CHANNELS is not a power of two; those read as 0 rather than off the
   // end of MuxIn.
   always_comb begin
      idx     = (Mode == MODE_SCAN) ? scanIndex : Sel;
      inRange = (32'(idx) < CHANNELS);
      word    = '0;
      if (inRange) begin
         word = MuxIn[32'(idx)*WIDTH +: WIDTH];
      end
   end

   // Output register. Data fields only change on an accept; when the
   // consumer drains without a new accept only OutValid falls.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         MuxOut   <= '0;
         OutSel   <= '0;
         OutLast  <= 1'b0;
         OutErr   <= 1'b0;
         OutValid <= 1'b0;
      end else if (accept) begin
         MuxOut   <= word;
         OutSel   <= idx;
         OutLast  <= (Mode == MODE_SCAN) && scanLast;
         OutErr   <= (Mode == MODE_DIRECT) && !inRange;
         OutValid <= 1'b1;
      end else if (OutReady) begin
         OutValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pipelined_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_pipelined_scan_mux
//   Directed bench for pipelined_scan_mux with WIDTH=8, CHANNELS=5 (SEL_W=3).
//   Inputs change #1 after a rising edge; outputs are sampled #1 after the
//   following rising edge.
// ---------------------------------------------------------------------------
module tb_pipelined_scan_mux;

   localparam int WIDTH    = 8;
   localparam int CHANNELS = 5;
   localparam int SEL_W    = 3;

   // ---------------- clock / reset ----------------
   logic                      Clock = 1'b0;
   logic                      Reset_n;
   logic                      Enable;
   logic                      Mode;
   logic [SEL_W-1:0]          Sel;
   logic [CHANNELS*WIDTH-1:0] MuxIn;
   logic                      InValid;
   logic                      InReady;
   logic [WIDTH-1:0]          MuxOut;
   logic [SEL_W-1:0]          OutSel;
   logic                      OutLast;
   logic                      OutErr;
   logic                      OutValid;
   logic                      OutReady;

   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   pipelined_scan_mux #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS)
   ) dut (
      .Clock    (Clock),
      .Reset_n  (Reset_n),
      .Enable   (Enable),
      .Mode     (Mode),
      .Sel      (Sel),
      .MuxIn    (MuxIn),
      .InValid  (InValid),
      .InReady  (InReady),
      .MuxOut   (MuxOut),
      .OutSel   (OutSel),
      .OutLast  (OutLast),
      .OutErr   (OutErr),
      .OutValid (OutValid),
      .OutReady (OutReady)
   );

   // ---------------- checking ----------------
   int nChecks = 0;
   int nPass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got === exp) begin
         nPass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- driver helpers ----------------
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Standard pattern: channel k = 8'h10 + k.
   task automatic loadDefaultWords();
      for (int k = 0; k < CHANNELS; k++) begin
         MuxIn[k*WIDTH +: WIDTH] = 8'h10 + 8'(k);
      end
   endtask

   task automatic checkOut(input string tag, input logic [7:0] expWord, input logic [2:0] expSel,
                           input logic expLast, input logic expErr, input logic expValid);
      check({tag, ".MuxOut"},   32'(MuxOut),   32'(expWord));
      check({tag, ".OutSel"},   32'(OutSel),   32'(expSel));
      check({tag, ".OutLast"},  32'(OutLast),  32'(expLast));
      check({tag, ".OutErr"},   32'(OutErr),   32'(expErr));
      check({tag, ".OutValid"}, 32'(OutValid), 32'(expValid));
   endtask

   // ---------------- scoreboard ----------------
   // Entry = {err, sel, word}
   logic [11:0] expQ[$];

   // ---------------- stimulus ----------------
   initial begin
      logic [11:0] e;
      logic [2:0]  s;
      logic [7:0]  w;

      Reset_n  = 1'b0;
      Enable   = 1'b1;
      Mode     = 1'b0;
      Sel      = '0;
      MuxIn    = '0;
      InValid  = 1'b0;
      OutReady = 1'b0;
      loadDefaultWords();
      tick();
      tick();
      checkOut("reset_init", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      Reset_n = 1'b1;
      tick();

      // ---- direct mode ----
      Mode = 1'b0; Sel = 3'd3; InValid = 1'b1; OutReady = 1'b1;
      tick();
      checkOut("direct_sel3", 8'h13, 3'd3, 1'b0, 1'b0, 1'b1);
      Sel = 3'd6;
      tick();
      checkOut("direct_sel6", 8'h00, 3'd6, 1'b0, 1'b1, 1'b1);
      Sel = 3'd4;
      tick();
      checkOut("direct_sel4", 8'h14, 3'd4, 1'b0, 1'b0, 1'b1);

      // ---- scan wrap: 0,1,2,3,4,0,1 ----
      Mode = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         checkOut($sformatf("scan_%0d", i), 8'h10 + 8'(i % 5), 3'(i % 5),
                  (i % 5) == 4, 1'b0, 1'b1);
      end
      // scan index is now 2

      // ---- backpressure ----
      OutReady = 1'b0;
      #1;
      check("bp_inready", 32'(InReady), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOut($sformatf("bp_hold_%0d", i), 8'h11, 3'd1, 1'b0, 1'b0, 1'b1);
         check($sformatf("bp_inready_%0d", i), 32'(InReady), 32'd0);
      end
      OutReady = 1'b1;
      #1;
      check("bp_release_inready", 32'(InReady), 32'd1);
      tick();
      checkOut("bp_resume", 8'h12, 3'd2, 1'b0, 1'b0, 1'b1);
      // scan index is now 3

      // ---- enable: drain without capture ----
      Enable = 1'b0; OutReady = 1'b0;
      #1;
      check("dis_inready", 32'(InReady), 32'd0);
      tick();
      checkOut("dis_hold", 8'h12, 3'd2, 1'b0, 1'b0, 1'b1);
      OutReady = 1'b1;
      tick();
      checkOut("dis_drain", 8'h12, 3'd2, 1'b0, 1'b0, 1'b0);
      tick();
      checkOut("dis_idle", 8'h12, 3'd2, 1'b0, 1'b0, 1'b0);

      // ---- mode 1 -> 0 -> 1 at index 3 restarts scan at 0 ----
      Enable = 1'b1; InValid = 1'b0; Mode = 1'b0;
      tick();
      check("mode_idle_valid", 32'(OutValid), 32'd0);
      Mode = 1'b1; InValid = 1'b1;
      tick();
      checkOut("mode_restart", 8'h10, 3'd0, 1'b0, 1'b0, 1'b1);
      // scan index is now 1

      // ---- async reset mid-transfer with OutValid=1 ----
      OutReady = 1'b0;
      Reset_n  = 1'b0;
      #1;
      checkOut("reset_async", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      check("reset_inready", 32'(InReady), 32'(Enable));
      tick();
      Reset_n  = 1'b1;
      OutReady = 1'b1;
      tick();
      checkOut("reset_scan_idx", 8'h10, 3'd0, 1'b0, 1'b0, 1'b1);

      // ---- streaming, direct mode, random Sel and data ----
      Mode = 1'b0;
      for (int i = 0; i < 24; i++) begin
         MuxIn = {8'($urandom), $urandom};
         s     = 3'($urandom_range(0, 7));
         Sel   = s;
         if (s < 3'(CHANNELS)) begin
            w = MuxIn[int'(s)*WIDTH +: WIDTH];
            expQ.push_back({1'b0, s, w});
         end else begin
            expQ.push_back({1'b1, s, 8'h00});
         end
         tick();
         e = expQ.pop_front();
         check($sformatf("stream_%0d.MuxOut", i), 32'(MuxOut), 32'(e[7:0]));
         check($sformatf("stream_%0d.OutSel", i), 32'(OutSel), 32'(e[10:8]));
         check($sformatf("stream_%0d.OutErr", i), 32'(OutErr), 32'(e[11]));
         check($sformatf("stream_%0d.OutValid", i), 32'(OutValid), 32'd1);
      end
      check("stream_queue_empty", 32'(expQ.size()), 32'd0);

      InValid = 1'b0;
      tick();
      check("final_drain", 32'(OutValid), 32'd0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
